// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C register-bank slave: FSM encoding and default bus address.
package i2c_slave_pkg;

  localparam logic [6:0] DEFAULT_ADDR = 7'h68;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for SCL/SDA with single-cycle rise/fall pulses on the synchronized values.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_rise,
  output logic sda_fall
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_q;
  logic       sda_q;

  // Idle bus level is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_q  <= scl_ff[1];
      sda_q  <= sda_ff[1];
    end
  end

  assign scl_s    = scl_ff[1];
  assign sda_s    = sda_ff[1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign sda_rise = sda_s & ~sda_q;
  assign sda_fall = ~sda_s & sda_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave fronting an NREG x 8 register bank: pointer write, burst write, burst read.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] ADDR = DEFAULT_ADDR,
  parameter int         NREG = 16,
  parameter int         HOLD = 8,
  localparam int        PW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  input  logic          sda_in,
  output logic          sda_out,
  output logic          sda_en,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [PW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          bus_wr,
  output logic          busy
);

  localparam int HW = $clog2(HOLD + 2);

  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall;

  i2c_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda_in),
    .scl_s    (scl_s),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_rise (sda_rise),
    .sda_fall (sda_fall)
  );

  state_t        state, state_next;
  logic [7:0]    bank [NREG];
  logic [7:0]    shreg;
  logic [7:0]    tx;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [HW-1:0] hold_cnt;
  logic          pend_out;
  logic          pend_en;

  logic          start, stop, byte_done;
  logic [7:0]    rx_byte;
  logic [2:0]    tx_idx;
  logic          sample, cnt_clr, sched, sched_out, sched_en, drop;
  logic          ld_ptr, bus_we, ptr_inc, ld_tx, busy_set, busy_clr;

  assign start     = sda_fall & scl_s;
  assign stop      = sda_rise & scl_s;
  assign byte_done = (bit_cnt == 4'd8);
  assign rx_byte   = {shreg[6:0], sda_s};
  assign tx_idx    = 3'd7 - bit_cnt[2:0];
  assign ptr_next  = (ptr == PW'(NREG - 1)) ? '0 : ptr + PW'(1);
  assign rd_data   = bank[rd_addr];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Bus events are acted on as strobes; sched queues an SDA change HOLD cycles later.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    cnt_clr    = 1'b0;
    sched      = 1'b0;
    sched_out  = 1'b1;
    sched_en   = 1'b0;
    drop       = 1'b0;
    ld_ptr     = 1'b0;
    bus_we     = 1'b0;
    ptr_inc    = 1'b0;
    ld_tx      = 1'b0;
    busy_set   = 1'b0;
    busy_clr   = 1'b0;
    if (start) begin
      state_next = S_ADDR;
      cnt_clr    = 1'b1;
      drop       = 1'b1;
    end else if (stop) begin
      state_next = S_IDLE;
      cnt_clr    = 1'b1;
      drop       = 1'b1;
      busy_clr   = 1'b1;
    end else begin
      case (state)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise && !byte_done) sample = 1'b1;
          if (scl_fall && byte_done) begin
            cnt_clr = 1'b1;
            if (shreg[7:1] == ADDR) begin
              state_next = S_ADDR_ACK;
              sched      = 1'b1;
              sched_out  = 1'b0;
              sched_en   = 1'b1;
              busy_set   = 1'b1;
            end else begin
              state_next = S_IDLE;
              drop       = 1'b1;
              busy_clr   = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_clr = 1'b1;
            sched   = 1'b1;
            if (shreg[0]) begin
              state_next = S_RDATA;
              ld_tx      = 1'b1;
              sched_out  = bank[ptr][7];
              sched_en   = 1'b1;
            end else begin
              state_next = S_PTR;
            end
          end
        end
        S_PTR: begin
          if (scl_rise && !byte_done) begin
            sample = 1'b1;
            ld_ptr = (bit_cnt == 4'd7);
          end
          if (scl_fall && byte_done) begin
            state_next = S_PTR_ACK;
            cnt_clr    = 1'b1;
            sched      = 1'b1;
            sched_out  = 1'b0;
            sched_en   = 1'b1;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state_next = S_WDATA;
            sched      = 1'b1;
          end
        end
        S_WDATA: begin
          // Commit on the 8th rise so a byte cut short by START/STOP never lands.
          if (scl_rise && !byte_done) begin
            sample  = 1'b1;
            bus_we  = (bit_cnt == 4'd7);
            ptr_inc = (bit_cnt == 4'd7);
          end
          if (scl_fall && byte_done) begin
            state_next = S_WDATA_ACK;
            cnt_clr    = 1'b1;
            sched      = 1'b1;
            sched_out  = 1'b0;
            sched_en   = 1'b1;
          end
        end
        S_RDATA: begin
          if (scl_rise && !byte_done) sample = 1'b1;
          if (scl_fall) begin
            if (byte_done) begin
              state_next = S_RDATA_ACK;
              cnt_clr    = 1'b1;
              sched      = 1'b1;
              ptr_inc    = 1'b1;
            end else if (bit_cnt != 4'd0) begin
              sched     = 1'b1;
              sched_out = tx[tx_idx];
              sched_en  = 1'b1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise && bit_cnt == 4'd0) sample = 1'b1;
          if (scl_fall) begin
            cnt_clr = 1'b1;
            if (!shreg[0]) begin
              state_next = S_RDATA;
              ld_tx      = 1'b1;
              sched      = 1'b1;
              sched_out  = bank[ptr][7];
              sched_en   = 1'b1;
            end else begin
              state_next = S_IDLE;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      tx       <= '0;
      bit_cnt  <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      pend_out <= 1'b1;
      pend_en  <= 1'b0;
      sda_out  <= 1'b1;
      sda_en   <= 1'b0;
      busy     <= 1'b0;
      bus_wr   <= 1'b0;
    end else begin
      bus_wr <= bus_we;
      if (sample) shreg <= rx_byte;
      if (cnt_clr)     bit_cnt <= '0;
      else if (sample) bit_cnt <= bit_cnt + 4'd1;
      if (ld_ptr)       ptr <= PW'({1'b0, rx_byte} % 9'(NREG));
      else if (ptr_inc) ptr <= ptr_next;
      if (ld_tx) tx <= bank[ptr];
      if (drop) begin
        hold_cnt <= '0;
        sda_out  <= 1'b1;
        sda_en   <= 1'b0;
      end else if (sched) begin
        hold_cnt <= HW'(HOLD);
        pend_out <= sched_out;
        pend_en  <= sched_en;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
        if (hold_cnt == HW'(1)) begin
          sda_out <= pend_out;
          sda_en  <= pend_en;
        end
      end
      if (busy_clr)      busy <= 1'b0;
      else if (busy_set) busy <= 1'b1;
    end
  end

  // Bus write is ordered after the fabric write so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else begin
      if (wr_en)  bank[wr_addr] <= wr_data;
      if (bus_we) bank[ptr]     <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master plus a register-array reference of the bank.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_in;
  logic       sda_out, sda_en;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       bus_wr, busy;

  logic [7:0] model [16];
  logic [7:0] wq [$];
  int n_chk = 0;
  int n_fail = 0;
  int wr_pulses = 0;
  int en_cycles = 0;

  assign sda_in = m_sda & (sda_en ? sda_out : 1'b1);

  i2c_slave dut (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda_in  (sda_in),
    .sda_out (sda_out),
    .sda_en  (sda_en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .bus_wr  (bus_wr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_wr) wr_pulses <= wr_pulses + 1;
    if (sda_en) en_cycles <= en_cycles + 1;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_start();
    if (scl == 1'b0) begin
      m_sda = 1'b1; #(Q);
      scl = 1'b1;   #(2*Q);
    end else begin
      m_sda = 1'b1; #(Q);
    end
    m_sda = 1'b0; #(2*Q);
    scl = 1'b0;   #(Q);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; #(Q);
    scl = 1'b1;   #(2*Q);
    m_sda = 1'b1; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; #(2*Q);
    scl = 1'b1; #(3*Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; #(2*Q);
    scl = 1'b1;   #(Q + Q/2);
    b = sda_in;   #(Q + Q/2);
    scl = 1'b0;   #(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic fab_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = 4'(i);
      #1;
      check($sformatf("%s_bank%0d", tag, i), {24'd0, rd_data}, {24'd0, model[i]});
    end
  endtask

  // Writes pointer byte p then every byte queued in wq, updating the reference bank.
  task automatic bus_write(input logic [7:0] p, input string tag);
    logic ack;
    m_start();
    write_byte(8'hD0, ack); check({tag, "_addr_ack"}, {31'd0, ack}, 32'd0);
    write_byte(p, ack);     check({tag, "_ptr_ack"}, {31'd0, ack}, 32'd0);
    for (int i = 0; i < wq.size(); i++) begin
      write_byte(wq[i], ack);
      check($sformatf("%s_data%0d_ack", tag, i), {31'd0, ack}, 32'd0);
      model[(int'(p) + i) % 16] = wq[i];
    end
    m_stop();
  endtask

  task automatic bus_read(input logic [7:0] p, input int n, input string tag);
    logic ack;
    logic [7:0] d;
    m_start();
    write_byte(8'hD0, ack); check({tag, "_waddr_ack"}, {31'd0, ack}, 32'd0);
    write_byte(p, ack);     check({tag, "_ptr_ack"}, {31'd0, ack}, 32'd0);
    m_start();
    write_byte(8'hD1, ack); check({tag, "_raddr_ack"}, {31'd0, ack}, 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1));
      check($sformatf("%s_rd%0d", tag, i), {24'd0, d}, {24'd0, model[(int'(p) + i) % 16]});
    end
    #(Q);
    check({tag, "_released_after_nack"}, {31'd0, sda_en}, 32'd0);
    m_stop();
  endtask

  initial begin
    logic ack;
    logic [7:0] p;
    int n, w0, e0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sda_en", {31'd0, sda_en}, 32'd0);
    check("rst_sda_out", {31'd0, sda_out}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bus_wr", {31'd0, bus_wr}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);

    // Basic write transaction
    w0 = wr_pulses;
    m_start();
    write_byte(8'hD0, ack); check("wr_addr_ack", {31'd0, ack}, 32'd0);
    check("wr_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h03, ack); check("wr_ptr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h5A, ack); check("wr_d0_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h7E, ack); check("wr_d1_ack", {31'd0, ack}, 32'd0);
    m_stop();
    model[3] = 8'h5A; model[4] = 8'h7E;
    check("wr_pulses", wr_pulses - w0, 32'd2);
    check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
    check_bank("wr");

    // Preloaded burst read through a repeated START
    for (int i = 0; i < 7; i++) fab_write(4'(i), 8'h10 + 8'(i));
    bus_read(8'h00, 7, "rd");

    // Wrong address
    e0 = en_cycles;
    m_start();
    write_byte(8'hA0, ack); check("bad_addr_nack", {31'd0, ack}, 32'd1);
    check("bad_addr_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h01, ack);
    m_stop();
    check("bad_addr_no_drive", en_cycles - e0, 32'd0);
    check_bank("bad");

    // Pointer wrap
    wq = '{8'hAA, 8'hBB};
    bus_write(8'h0F, "wrap");
    check_bank("wrap");

    // Fabric and bus write to index 4 in the same cycle
    m_start();
    write_byte(8'hD0, ack); check("col_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h04, ack); check("col_ptr_ack", {31'd0, ack}, 32'd0);
    fork
      write_byte(8'h22, ack);
      begin
        wr_addr = 4'd4; wr_data = 8'h11; wr_en = 1'b1;
        for (int k = 0; k < 2000; k++) begin
          @(negedge clk);
          if (bus_wr) break;
        end
        wr_en = 1'b0;
      end
    join
    check("col_data_ack", {31'd0, ack}, 32'd0);
    m_stop();
    model[4] = 8'h22;
    check_bank("col");

    // Random write/read-back bursts, full 8-bit pointer byte exercises modulo
    for (int r = 0; r < 3; r++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
      w0 = wr_pulses;
      bus_write(p, $sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_pulses", r), wr_pulses - w0, n);
      bus_read(p, n, $sformatf("rnd%0d_rb", r));
    end

    // Reset in the middle of a read byte
    p = 8'($urandom_range(0, 15));
    m_start();
    write_byte(8'hD0, ack);
    write_byte(p, ack);
    m_start();
    write_byte(8'hD1, ack); check("rst_rd_addr_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < 3; i++) read_bit(ack);
    #(Q);
    check("rst_rd_driving", {31'd0, sda_en}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_release", {31'd0, sda_en}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    m_stop();
    wq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    bus_write(8'($urandom_range(0, 15)), "post_rst");
    check_bank("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
